// File: rtl/tx_pkg.sv
// Shared types and constants for the transmit frame sequencer.
// Build option: define TX_SEQ_CRC_EN to add the trailing CRC-8 field and its state.
package tx_pkg;

  localparam int unsigned SYNC_WIDTH = 16;
  localparam logic [SYNC_WIDTH-1:0] SYNC_WORD_DEFAULT = 16'hD391;
  localparam logic [7:0] CRC8_POLY = 8'h07;

`ifdef TX_SEQ_CRC_EN
  typedef enum logic [2:0] {StIdle, StPreamble, StSync, StPayload, StCrc} tx_state_e;
`else
  typedef enum logic [1:0] {StIdle, StPreamble, StSync, StPayload} tx_state_e;
`endif

  // One MSB-first step of CRC-8 (no reflection, no final XOR).
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator over the payload bits in transmit order.
// Only instantiated when TX_SEQ_CRC_EN is defined.
module crc8_serial
  import tx_pkg::*;
(
  input  logic       CLK,
  input  logic       reset,
  input  logic       clear,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic [7:0] crc
);

  logic [7:0] crc_q;

  // Remainder register; clear wins so every frame starts from zero.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      crc_q <= 8'h00;
    end else if (clear) begin
      crc_q <= 8'h00;
    end else if (bit_valid) begin
      crc_q <= crc8_step(crc_q, bit_in);
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/tx_frame_sequencer.sv
// Transmit frame sequencer: preamble, sync word, payload bytes and optional CRC-8,
// each bit held for SPS clocks, driving the modulator DATA bit and enable.
// Build option: TX_SEQ_CRC_EN appends a CRC-8 of the payload after the last byte.
module tx_frame_sequencer
  import tx_pkg::*;
#(
  parameter int unsigned              SPS          = 4,
  parameter int unsigned              PREAMBLE_LEN = 8,
  parameter logic [SYNC_WIDTH-1:0]    SYNC_WORD    = SYNC_WORD_DEFAULT
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] frame_len,
  input  logic [7:0] byte_data,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       data_bit,
  output logic       sym_stb,
  output logic       mod_enable,
  output logic       busy,
  output logic       frame_done,
  output logic       underrun
);

  localparam int unsigned CntW   = $clog2(SPS);
  localparam int unsigned IdxLim = (PREAMBLE_LEN > SYNC_WIDTH) ? PREAMBLE_LEN : SYNC_WIDTH;
  localparam int unsigned IdxW   = $clog2(IdxLim);

  tx_state_e             state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [SYNC_WIDTH-1:0] shreg_q, shreg_d;
  logic [7:0]            buf_q, buf_d;
  logic                  buf_full_q, buf_full_d;
  logic [7:0]            fetch_rem_q, fetch_rem_d;
  logic [7:0]            send_rem_q, send_rem_d;
  logic                  data_bit_q, data_bit_d;
  logic                  sym_stb_q, sym_stb_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  underrun_q, underrun_d;
  logic                  ready_q, ready_d;

  logic xfer, last_sym;
  logic shift_bit, tail, load, abort, finish;

`ifdef TX_SEQ_CRC_EN
  logic       crc_clear, crc_valid, crc_bit;
  logic [7:0] crc_val;

  crc8_serial u_crc (
    .CLK       (CLK),
    .reset     (reset),
    .clear     (crc_clear),
    .bit_valid (crc_valid),
    .bit_in    (crc_bit),
    .crc       (crc_val)
  );
`endif

  assign xfer     = byte_valid && ready_q;
  assign last_sym = (cnt_q == CntW'(SPS - 1));

  // Next state, datapath and next values of the registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    fetch_rem_d = fetch_rem_q;
    send_rem_d  = send_rem_q;
    data_bit_d  = data_bit_q;
    sym_stb_d   = 1'b0;
    done_d      = 1'b0;
    underrun_d  = 1'b0;
    shift_bit   = 1'b0;
    tail        = 1'b0;
    load        = 1'b0;
    abort       = 1'b0;
    finish      = 1'b0;
`ifdef TX_SEQ_CRC_EN
    crc_clear   = 1'b0;
    crc_valid   = 1'b0;
    crc_bit     = 1'b0;
`endif

    if (xfer) begin
      buf_d       = byte_data;
      buf_full_d  = 1'b1;
      fetch_rem_d = fetch_rem_q - 8'd1;
    end

    if (state_q == StIdle) begin
      if (start) begin
        state_d     = StPreamble;
        cnt_d       = '0;
        idx_d       = '0;
        data_bit_d  = 1'b1;
        sym_stb_d   = 1'b1;
        fetch_rem_d = frame_len;
        send_rem_d  = frame_len;
        buf_full_d  = 1'b0;
`ifdef TX_SEQ_CRC_EN
        crc_clear   = 1'b1;
`endif
      end
    end else if (!last_sym) begin
      cnt_d = cnt_q + CntW'(1);
    end else begin
      cnt_d     = '0;
      sym_stb_d = 1'b1;
      unique case (state_q)
        StPreamble: begin
          if (idx_q == IdxW'(PREAMBLE_LEN - 1)) begin
            state_d    = StSync;
            idx_d      = '0;
            shreg_d    = SYNC_WORD;
            data_bit_d = SYNC_WORD[SYNC_WIDTH-1];
          end else begin
            idx_d      = idx_q + IdxW'(1);
            data_bit_d = ~idx_d[0];
          end
        end
        StSync: begin
          if (idx_q == IdxW'(SYNC_WIDTH - 1)) tail = 1'b1;
          else shift_bit = 1'b1;
        end
        StPayload: begin
          if (idx_q == IdxW'(7)) tail = 1'b1;
          else shift_bit = 1'b1;
        end
`ifdef TX_SEQ_CRC_EN
        StCrc: begin
          if (idx_q == IdxW'(7)) finish = 1'b1;
          else shift_bit = 1'b1;
        end
`endif
        default: begin
          state_d   = StIdle;
          sym_stb_d = 1'b0;
        end
      endcase
    end

    // End of sync or of a payload byte with nothing left to send.
    if (tail && send_rem_q == 8'd0) begin
`ifdef TX_SEQ_CRC_EN
      state_d    = StCrc;
      idx_d      = '0;
      shreg_d    = {crc_val, 8'h00};
      data_bit_d = crc_val[7];
`else
      finish     = 1'b1;
`endif
    end

    // A byte is due: take it from the buffer, or straight from a transfer
    // happening on this same boundary; otherwise the frame underruns.
    if (tail && send_rem_q != 8'd0) begin
      if (buf_full_q) begin
        shreg_d    = {buf_q, 8'h00};
        buf_full_d = 1'b0;
        load       = 1'b1;
      end else if (xfer) begin
        shreg_d    = {byte_data, 8'h00};
        buf_full_d = 1'b0;
        load       = 1'b1;
      end else begin
        abort      = 1'b1;
      end
    end

    if (load) begin
      state_d    = StPayload;
      idx_d      = '0;
      send_rem_d = send_rem_q - 8'd1;
      data_bit_d = shreg_d[SYNC_WIDTH-1];
    end

    if (shift_bit) begin
      idx_d      = idx_q + IdxW'(1);
      shreg_d    = {shreg_q[SYNC_WIDTH-2:0], 1'b0};
      data_bit_d = shreg_d[SYNC_WIDTH-1];
    end

`ifdef TX_SEQ_CRC_EN
    crc_valid = load || (shift_bit && state_q == StPayload);
    crc_bit   = data_bit_d;
`endif

    if (abort || finish) begin
      state_d    = StIdle;
      cnt_d      = '0;
      idx_d      = '0;
      data_bit_d = 1'b0;
      sym_stb_d  = 1'b0;
      buf_full_d = 1'b0;
    end
    underrun_d = abort;
    done_d     = finish;

    busy_d  = (state_d != StIdle);
    ready_d = (state_d == StSync || state_d == StPayload) && !buf_full_d &&
              (fetch_rem_d != 8'd0);
  end

  // State register and registered outputs.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= '0;
      shreg_q     <= '0;
      buf_q       <= 8'h00;
      buf_full_q  <= 1'b0;
      fetch_rem_q <= 8'h00;
      send_rem_q  <= 8'h00;
      data_bit_q  <= 1'b0;
      sym_stb_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underrun_q  <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      buf_q       <= buf_d;
      buf_full_q  <= buf_full_d;
      fetch_rem_q <= fetch_rem_d;
      send_rem_q  <= send_rem_d;
      data_bit_q  <= data_bit_d;
      sym_stb_q   <= sym_stb_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      underrun_q  <= underrun_d;
      ready_q     <= ready_d;
    end
  end

  assign byte_ready = ready_q;
  assign data_bit   = data_bit_q;
  assign sym_stb    = sym_stb_q;
  assign mod_enable = busy_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign underrun   = underrun_q;

endmodule
